// File: rtl/fetch_queue_pkg.sv
// Shared constants and the storage entry layout for the 2-wide fetch queue.
package fetch_queue_pkg;

  localparam int INSN_LEN = 32;
  localparam int FQ_DEPTH = 8;
  localparam logic [INSN_LEN-1:0] RV32_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]         pc;
    logic [INSN_LEN-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Queue storage: DEPTH entries, two write ports and two asynchronous read ports.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_a,
  input  logic [PTR_W-1:0] waddr_a,
  input  fq_entry_t        wdata_a,
  input  logic             we_b,
  input  logic [PTR_W-1:0] waddr_b,
  input  fq_entry_t        wdata_b,
  input  logic [PTR_W-1:0] raddr_a,
  output fq_entry_t        rdata_a,
  input  logic [PTR_W-1:0] raddr_b,
  output fq_entry_t        rdata_b
);

  fq_entry_t mem [DEPTH];

  // The parent only ever writes two distinct consecutive slots, so the ports never collide.
  always_ff @(posedge clk) begin
    if (we_a) mem[waddr_a] <= wdata_a;
    if (we_b) mem[waddr_b] <= wdata_b;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/fetch_queue.sv
// 2-wide circular instruction queue between fetch and the two decoders;
// presents the two oldest entries in program order and drops everything on flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                enq_valid_i,
  input  logic                enq_inst2_valid_i,
  input  logic [31:0]         enq_pc_i,
  input  logic [INSN_LEN-1:0] enq_inst1_i,
  input  logic [INSN_LEN-1:0] enq_inst2_i,
  output logic                enq_ready_o,
  input  logic                deq_ready_i,
  output logic                deq_valid1_o,
  output logic                deq_valid2_o,
  output logic [INSN_LEN-1:0] deq_inst1_o,
  output logic [31:0]         deq_pc1_o,
  output logic [INSN_LEN-1:0] deq_inst2_o,
  output logic [31:0]         deq_pc2_o,
  output logic [PTR_W:0]      count_o
);

  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;
  logic             enq_fire, enq_two, deq_fire, deq_two;
  logic [1:0]       n_enq, n_deq;
  fq_entry_t        wdata_a, wdata_b, rdata_a, rdata_b;

  // Ready looks only at registered occupancy; a same-cycle pop earns no credit.
  assign enq_ready_o  = (count_q <= (PTR_W+1)'(DEPTH - 2));
  assign deq_valid1_o = (count_q != '0);
  assign deq_valid2_o = (count_q >= (PTR_W+1)'(2));

  assign enq_fire = enq_valid_i & enq_ready_o & ~flush_i;
  assign enq_two  = enq_fire & enq_inst2_valid_i;
  assign deq_fire = deq_ready_i & deq_valid1_o & ~flush_i;
  assign deq_two  = deq_fire & deq_valid2_o;

  assign n_enq = enq_two ? 2'd2 : (enq_fire ? 2'd1 : 2'd0);
  assign n_deq = deq_two ? 2'd2 : (deq_fire ? 2'd1 : 2'd0);

  assign wdata_a = '{pc: enq_pc_i,         inst: enq_inst1_i};
  assign wdata_b = '{pc: enq_pc_i + 32'd4, inst: enq_inst2_i};

  fetch_queue_ram #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_ram (
    .clk     (clk_i),
    .we_a    (enq_fire),
    .waddr_a (tail_q),
    .wdata_a (wdata_a),
    .we_b    (enq_two),
    .waddr_b (tail_q + PTR_W'(1)),
    .wdata_b (wdata_b),
    .raddr_a (head_q),
    .rdata_a (rdata_a),
    .raddr_b (head_q + PTR_W'(1)),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(n_deq);
      tail_q  <= tail_q + PTR_W'(n_enq);
      count_q <= count_q + (PTR_W+1)'(n_enq) - (PTR_W+1)'(n_deq);
    end
  end

  // Bubbles carry a NOP so the decoders never flag an illegal instruction on them.
  assign deq_inst1_o = deq_valid1_o ? rdata_a.inst : RV32_NOP;
  assign deq_pc1_o   = deq_valid1_o ? rdata_a.pc   : 32'd0;
  assign deq_inst2_o = deq_valid2_o ? rdata_b.inst : RV32_NOP;
  assign deq_pc2_o   = deq_valid2_o ? rdata_b.pc   : 32'd0;
  assign count_o     = count_q;

endmodule
